// File: rtl/div_seq.sv
// rtl/div_seq.sv - radix-2 restoring sequential divider, signed/unsigned, with ALU flag set
// One quotient bit per clock on magnitudes; signs are reapplied in a single FIX cycle.
module div_seq #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             warn,
    output logic             error
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [CNTW-1:0]  cnt;
    logic [WIDTH-1:0] r_q, q_q, mb_q;
    logic [WIDTH-1:0] quot_r, rem_r;
    logic             sq, sr;
    logic             ovf_r, warn_r, err_r;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   shifted, trial;

    assign a_neg   = sgn & a[WIDTH-1];
    assign b_neg   = sgn & b[WIDTH-1];
    assign abs_a   = a_neg ? -a : a;
    assign abs_b   = b_neg ? -b : b;
    // Shifted remainder can reach WIDTH+1 bits for large unsigned divisors.
    assign shifted = {r_q, q_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, mb_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            r_q    <= '0;
            q_q    <= '0;
            mb_q   <= '0;
            quot_r <= '0;
            rem_r  <= '0;
            sq     <= 1'b0;
            sr     <= 1'b0;
            ovf_r  <= 1'b0;
            warn_r <= 1'b0;
            err_r  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (!en && start) begin
                        ovf_r  <= 1'b0;
                        err_r  <= 1'b0;
                        warn_r <= 1'b0;
                        sq     <= a_neg ^ b_neg;
                        sr     <= a_neg;
                        if (b == '0) begin
                            quot_r <= '1;
                            rem_r  <= a;
                            err_r  <= 1'b1;
                            state  <= S_DONE;
                        end else if (sgn && a == INT_MIN && b == '1) begin
                            quot_r <= INT_MIN;
                            rem_r  <= '0;
                            ovf_r  <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            cnt   <= CNTW'(WIDTH - 1);
                            r_q   <= '0;
                            q_q   <= abs_a;
                            mb_q  <= abs_b;
                            busy  <= 1'b1;
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (en) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        if (start)
                            warn_r <= 1'b1;
                        r_q <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                        q_q <= {q_q[WIDTH-2:0], ~trial[WIDTH]};
                        cnt <= cnt - 1'b1;
                        if (cnt == '0)
                            state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (en) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        if (start)
                            warn_r <= 1'b1;
                        quot_r <= sq ? -q_q : q_q;
                        rem_r  <= sr ? -r_q : r_q;
                        busy   <= 1'b0;
                        state  <= S_DONE;
                    end
                end
                default: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign quot     = en ? {WIDTH{1'bz}} : quot_r;
    assign rem      = en ? {WIDTH{1'bz}} : rem_r;
    assign zero     = en ? 1'bz : ~|quot_r;
    assign carry    = en ? 1'bz : 1'b0;
    assign overflow = en ? 1'bz : ovf_r;
    assign warn     = en ? 1'bz : warn_r;
    assign error    = en ? 1'bz : err_r;

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - scoreboard bench for div_seq against an arithmetic reference model
// Driver pushes expected results; a negedge monitor pops and compares on every done pulse.
module tb_div_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         start = 1'b0;
    logic         sgn = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    wire  [W-1:0] quot, rem;
    wire          busy, done, zero, carry, overflow, warn, error;

    div_seq #(.WIDTH(W), .CNTW(5)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .sgn(sgn),
        .a(a), .b(b), .quot(quot), .rem(rem), .busy(busy), .done(done),
        .zero(zero), .carry(carry), .overflow(overflow), .warn(warn), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        logic         ov;
        logic         er;
        int           lat;
    } exp_t;

    int           n_chk = 0;
    int           n_fail = 0;
    exp_t         sbq[$];
    int           exp_lat = 0;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int   sx, sy;
        e.ov = 1'b0;
        e.er = 1'b0;
        e.lat = 34;
        if (y == 0) begin
            e.q = '1; e.r = x; e.er = 1'b1; e.lat = 1;
        end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            e.q = x; e.r = '0; e.ov = 1'b1; e.lat = 1;
        end else if (s) begin
            sx = x; sy = y;
            e.q = sx / sy;
            e.r = sx % sy;
        end else begin
            e.q = x / y;
            e.r = x % y;
        end
        e.z = (e.q == 0);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL spurious_done: got done=1 expected no pending result");
            end else begin
                e = sbq.pop_front();
                chk("quot", quot, e.q);
                chk("rem", rem, e.r);
                chk("zero", zero, e.z);
                chk("overflow", overflow, e.ov);
                chk("error", error, e.er);
                chk("carry", carry, 1'b0);
            end
        end
    end

    task automatic issue(input logic s, input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
        exp_t e;
        @(negedge clk);
        sgn = s; a = x; b = y; start = 1'b1;
        e = model(s, x, y);
        if (push) begin
            sbq.push_back(e);
            exp_lat = e.lat;
            last_q = e.q;
            last_r = e.r;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom; sgn = 1'($urandom);
    endtask

    task automatic wait_done(output int n, output int bc);
        n = 0;
        bc = busy ? 1 : 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (busy) bc++;
        end while (!done && n < 200);
    endtask

    task automatic run(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        int n, bc;
        issue(s, x, y, 1'b1);
        wait_done(n, bc);
        chk("latency", n, exp_lat);
        chk("busy_cycles", bc, (exp_lat == 34) ? 33 : 0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return W'($urandom_range(0, 20));
            4:       return -W'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bc, dc;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_quot", quot, 32'h0);
        chk("rst_rem", rem, 32'h0);
        chk("rst_zero", zero, 1'b1);
        chk("rst_carry", carry, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_warn", warn, 1'b0);
        chk("rst_err", error, 1'b0);
        rst_n = 1'b1;

        run(1'b0, 32'd100, 32'd7);
        run(1'b1, 32'hFFFF_FFF9, 32'd2);
        run(1'b1, 32'd7, 32'hFFFF_FFFE);
        run(1'b0, 32'h1234_5678, 32'd0);
        run(1'b0, 32'd3, 32'd5);
        run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);

        // Dropped start while busy sets a sticky warn
        issue(1'b0, 32'd1000, 32'd3, 1'b1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1; a = 32'd5; b = 32'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("warn_set", warn, 1'b1);
        chk("warn_busy", busy, 1'b1);
        wait_done(n, bc);
        chk("warn_done", done, 1'b1);
        chk("warn_sticky", warn, 1'b1);
        issue(1'b0, 32'd9, 32'd4, 1'b1);
        chk("warn_clear", warn, 1'b0);
        wait_done(n, bc);
        chk("latency_after_warn", n, 34);

        // Disable mid-CALC aborts without a done pulse
        issue(1'b0, 32'd500, 32'd7, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", busy, 1'b0);
        dc = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dc++;
        end
        chk("abort_no_done", dc, 0);
        @(negedge clk);
        en = 1'b0;
        #1;
        chk("abort_quot_held", quot, last_q);
        chk("abort_rem_held", rem, last_r);
        run(1'b0, 32'd100, 32'd7);

        // Asynchronous reset mid-CALC
        issue(1'b1, -32'd1000, 32'd7, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_quot", quot, 32'h0);
        chk("arst_zero", zero, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        last_q = '0;
        last_r = '0;

        for (int i = 0; i < 60; i++)
            run(1'($urandom), pick(), pick());

        repeat (4) @(posedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
